cache_refill_ctrl: RTL and testbench
====================================

// Module: cache_refill_ctrl
// PURPOSE
//  Miss-side controller between the 2-way set-associative cache (3-bit data) and the
//  16x3 synchronous main memory. Takes one miss request at a time, holding a refill
//  address plus an optional dirty victim. Victims are parked in a small write-back
//  buffer and drained when the controller is idle. Refill data is read from memory,
//  or forwarded from the buffer, and returned to the cache with a one-cycle pulse.
// PARAMETERS
//  ADDR_W    4  main-memory word address width (tag[1:0] + index)
//  DATA_W    3  data word width
//  WB_DEPTH  2  write-back buffer entries (>=1)
//  RAM_LAT   1  main-memory read latency in cycles, address to q (>=1)
// PORTS
//  clock        in   1        single clock, rising edge
//  reset        in   1        asynchronous, active-high; clears all state
//  req_valid    in   1        cache miss request
//  req_ready    out  1        request accepted on req_valid && req_ready
//  req_addr     in   ADDR_W   refill word address
//  req_wb       in   1        victim is dirty; push it to the buffer on accept
//  req_wb_addr  in   ADDR_W   victim word address
//  req_wb_data  in   DATA_W   victim data
//  resp_valid   out  1        one-cycle pulse, refill data valid
//  resp_data    out  DATA_W   refill data; held until the next response
//  mem_addr     out  ADDR_W   main-memory address
//  mem_wdata    out  DATA_W   main-memory write data
//  mem_wren     out  1        main-memory write enable
//  mem_q        in   DATA_W   main-memory read data, RAM_LAT cycles after mem_addr
//  wb_count     out  clog2(WB_DEPTH+1)  occupied buffer entries
//  busy         out  1        state!=IDLE || wb_count!=0
// BEHAVIOUR
//  Reset: state=IDLE, buffer empty; resp_valid, resp_data, mem_addr, mem_wdata,
//   mem_wren, wb_count and busy are all 0. req_ready=1.
//  FSM states: IDLE, DRAIN, RD_ISSUE, RD_WAIT, RESP.
//  req_ready = (state==IDLE) && (wb_count<WB_DEPTH). It is combinational.
//  IDLE, request accepted at cycle N:
//   - if req_wb: push {req_wb_addr, req_wb_data}. If an entry with the same address
//     already exists, overwrite that entry's data in place (coalesce, count unchanged).
//   - Forward check: compare req_addr against all valid entries, including the victim
//     pushed this cycle. On a match, take data from the youngest matching entry.
//     Next state = RESP, so resp_valid is high in cycle N+1. No memory read is issued.
//   - On no match, next state = RD_ISSUE.
//  IDLE, no accept, buffer not empty -> DRAIN.
//  DRAIN (1 cycle): mem_wren=1, with mem_addr/mem_wdata taken from the head entry.
//   Pop the head at the end of the cycle, then -> IDLE.
//  RD_ISSUE (1 cycle): mem_addr=req_addr (latched), mem_wren=0 -> RD_WAIT.
//  RD_WAIT: remains for RAM_LAT cycles (counter). mem_q is sampled into resp_data at
//   the end of the last cycle -> RESP.
//  RESP (1 cycle): resp_valid=1 -> IDLE.
//  Latency: miss, no forward: resp_valid at N+2+RAM_LAT. Forwarded: N+1.
//  mem_wren is high only in DRAIN. Reads and writes never overlap.
//  Priority: an accepted request beats a drain. When the buffer is full, req_ready=0,
//   so a drain is forced and the request is accepted on the next IDLE cycle.
//  Write-after-read ordering is safe because the buffer is checked before memory.
//   Read-after-write ordering is safe by forwarding.
//  Buffer is a circular FIFO. Head and tail pointers wrap modulo WB_DEPTH.
//   Count is 0..WB_DEPTH.
//  Reset in mid-operation: the FSM aborts to IDLE and buffered victims are discarded.
//   The cache must also be reset.
//  req_wb_addr==req_addr in one request is illegal. Flag it with a simulation assertion.
//  Inputs are ignored unless they are accepted. The latched request is stable until RESP.
// STRUCTURE
//  Shared package cache_mem_pkg holds:
//   - ADDR_W and DATA_W defaults;
//   - the state encoding (IDLE=0, DRAIN=1, RD_ISSUE=2, RD_WAIT=3, RESP=4);
//   - the wb_entry_t record {valid, addr, data}.
//  Sub-module wb_fifo holds:
//   - storage, pointers and count;
//   - coalescing push and head pop;
//   - a parallel address match that returns hit and the youngest data.
//  The top level holds the FSM, latency counter and output registers.
// TESTING
//  1. Clean miss: req_addr=5, req_wb=0, mem[5]=3'b011. Expect mem_addr=5 at N+1,
//     resp_valid at N+3 with resp_data=3'b011, and mem_wren=0 throughout.
//  2. Dirty miss: req_addr=9, victim addr=1 data=3'b110. Expect wb_count=1, then the
//     read response. DRAIN follows: mem_wren=1, addr=1, data=3'b110, wb_count back to 0.
//  3. Forward: buffer holds addr=6 data=3'b101 (drain stalled by back-to-back requests),
//     then request req_addr=6. Expect resp_valid at N+1, resp_data=3'b101, no mem read.
//  4. Full buffer (WB_DEPTH=2): two dirty misses back to back, then a third req_valid.
//     Expect req_ready=0 until one DRAIN completes, then accept. Memory contents match
//     the victims in FIFO order.
//  5. Coalesce: two victims with addr=3 (data 3'b001, then 3'b111). Expect wb_count=1
//     and a single drain writing 3'b111.
//  6. Reset asserted during RD_WAIT: outputs go to 0 asynchronously and
//     wb_count=0. The first request after deassert completes normally.

Source files
------------

// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache miss path: default widths, refill FSM
// encoding and the write-back buffer entry record.
package cache_mem_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RESP     = 3'd4
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Write-back victim buffer: circular FIFO with coalescing push, head pop and
// a parallel address lookup returning the youngest matching data.
module wb_fifo
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int WB_DEPTH = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [ADDR_W-1:0]            head_addr,
    output logic [DATA_W-1:0]            head_data,
    output logic [$clog2(WB_DEPTH+1)-1:0] count,
    input  logic [ADDR_W-1:0]            lk_addr,
    output logic                         lk_hit,
    output logic [DATA_W-1:0]            lk_data
);

    localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int CNT_W = $clog2(WB_DEPTH+1);

    logic [WB_DEPTH-1:0] valid;
    logic [ADDR_W-1:0]   addr_mem [WB_DEPTH];
    logic [DATA_W-1:0]   data_mem [WB_DEPTH];
    logic [PTR_W-1:0]    head, tail;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic                co_hit;
    logic [PTR_W-1:0]    co_idx;
    logic                push_new, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(WB_DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        co_hit = 1'b0;
        co_idx = '0;
        for (int unsigned i = 0; i < WB_DEPTH; i++) begin
            if (valid[PTR_W'(i)] && addr_mem[PTR_W'(i)] == push_addr) begin
                co_hit = 1'b1;
                co_idx = PTR_W'(i);
            end
        end
    end

    // Walk oldest to youngest so the last match wins; a victim pushed this
    // cycle is younger than anything already stored.
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        for (int unsigned k = 0; k < WB_DEPTH; k++) begin
            if (valid[PTR_W'((head + k) % WB_DEPTH)] &&
                addr_mem[PTR_W'((head + k) % WB_DEPTH)] == lk_addr) begin
                lk_hit  = 1'b1;
                lk_data = data_mem[PTR_W'((head + k) % WB_DEPTH)];
            end
        end
        if (push && push_addr == lk_addr) begin
            lk_hit  = 1'b1;
            lk_data = push_data;
        end
    end

    assign push_new  = push && !co_hit && (cnt < CNT_W'(WB_DEPTH));
    assign pop_ok    = pop && (cnt != '0);
    assign head_addr = addr_mem[head];
    assign head_data = data_mem[head];
    assign count     = cnt;

    always_comb begin
        cnt_nx = cnt;
        if (push_new) cnt_nx = cnt_nx + 1'b1;
        if (pop_ok)   cnt_nx = cnt_nx - 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            for (int unsigned i = 0; i < WB_DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            if (pop_ok) begin
                valid[head] <= 1'b0;
                head        <= ptr_inc(head);
            end
            if (push && co_hit) begin
                data_mem[co_idx] <= push_data;
            end else if (push_new) begin
                valid[tail]    <= 1'b1;
                addr_mem[tail] <= push_addr;
                data_mem[tail] <= push_data;
                tail           <= ptr_inc(tail);
            end
            cnt <= cnt_nx;
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-side refill controller: accepts one miss at a time, parks dirty victims
// in the write-back buffer, forwards from it or reads main memory.
module cache_refill_ctrl
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int WB_DEPTH = 2,
    parameter int RAM_LAT  = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic                          req_wb,
    input  logic [ADDR_W-1:0]             req_wb_addr,
    input  logic [DATA_W-1:0]             req_wb_data,
    output logic                          resp_valid,
    output logic [DATA_W-1:0]             resp_data,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic                          mem_wren,
    input  logic [DATA_W-1:0]             mem_q,
    output logic [$clog2(WB_DEPTH+1)-1:0] wb_count,
    output logic                          busy
);

    localparam int CNT_W = $clog2(WB_DEPTH+1);
    localparam int LAT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] resp_q;
    logic [LAT_W-1:0]  lat_cnt;
    logic              lat_last;
    logic              accept;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              lk_hit;
    logic [DATA_W-1:0] lk_data;

    wb_fifo #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .WB_DEPTH (WB_DEPTH)
    ) u_wb (
        .clock     (clock),
        .reset     (reset),
        .push      (accept && req_wb),
        .push_addr (req_wb_addr),
        .push_data (req_wb_data),
        .pop       (state == DRAIN),
        .head_addr (head_addr),
        .head_data (head_data),
        .count     (wb_count),
        .lk_addr   (req_addr),
        .lk_hit    (lk_hit),
        .lk_data   (lk_data)
    );

    assign req_ready = (state == IDLE) && (wb_count < CNT_W'(WB_DEPTH));
    assign accept    = req_valid && req_ready;
    assign lat_last  = (lat_cnt == LAT_W'(RAM_LAT-1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept)               state_nx = lk_hit ? RESP : RD_ISSUE;
                else if (wb_count != '0)  state_nx = DRAIN;
            end
            DRAIN:    state_nx = IDLE;
            RD_ISSUE: state_nx = RD_WAIT;
            RD_WAIT:  if (lat_last) state_nx = RESP;
            RESP:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_wren  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            DRAIN: begin
                mem_wren  = 1'b1;
                mem_addr  = head_addr;
                mem_wdata = head_data;
            end
            RD_ISSUE, RD_WAIT: mem_addr = addr_q;
            default: ;
        endcase
    end

    assign resp_valid = (state == RESP);
    assign resp_data  = resp_q;
    assign busy       = (state != IDLE) || (wb_count != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            resp_q  <= '0;
            lat_cnt <= '0;
        end else begin
            state <= state_nx;
            if (accept) addr_q <= req_addr;
            if (accept && lk_hit) resp_q <= lk_data;
            if (state == RD_ISSUE) begin
                lat_cnt <= '0;
            end else if (state == RD_WAIT) begin
                lat_cnt <= lat_cnt + 1'b1;
                if (lat_last) resp_q <= mem_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && accept && req_wb)
            assert (req_wb_addr != req_addr)
            else $error("cache_refill_ctrl: victim address equals refill address");
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl with a behavioural 16x3 synchronous memory.
module tb_cache_refill_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_addr = '0;
    logic       req_wb = 1'b0;
    logic [3:0] req_wb_addr = '0;
    logic [2:0] req_wb_data = '0;
    logic       resp_valid;
    logic [2:0] resp_data;
    logic [3:0] mem_addr;
    logic [2:0] mem_wdata;
    logic       mem_wren;
    logic [2:0] mem_q;
    logic [1:0] wb_count;
    logic       busy;

    logic [2:0] mem [16];
    int         wren_cycles = 0;
    int         total = 0;
    int         bad = 0;
    int         w0;

    cache_refill_ctrl #(
        .ADDR_W   (4),
        .DATA_W   (3),
        .WB_DEPTH (2),
        .RAM_LAT  (1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_wb      (req_wb),
        .req_wb_addr (req_wb_addr),
        .req_wb_data (req_wb_data),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q),
        .wb_count    (wb_count),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [2:0] init_val(input int a);
        case (a)
            2:       return 3'b010;
            5:       return 3'b011;
            7:       return 3'b111;
            9:       return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
            mem_q <= '0;
        end else begin
            if (mem_wren) begin
                mem[mem_addr] <= mem_wdata;
                wren_cycles   <= wren_cycles + 1;
            end
            mem_q <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 30 && busy !== 1'b0; i++) tick();
        chk(tag, busy, 0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_wren", mem_wren, 0);
        chk("rst_wb_count", wb_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 1);
        reset = 1'b0;
        tick();

        // 1: clean miss to address 5
        req_valid = 1'b1; req_addr = 4'd5; req_wb = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("t1_mem_addr", mem_addr, 5);
        chk("t1_wren_a", mem_wren, 0);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_noresp", resp_valid, 0);
        chk("t1_wren_b", mem_wren, 0);
        tick();
        chk("t1_resp_valid", resp_valid, 1);
        chk("t1_resp_data", resp_data, 3'b011);
        chk("t1_wren_c", mem_wren, 0);
        tick();
        chk("t1_resp_pulse", resp_valid, 0);
        chk("t1_resp_hold", resp_data, 3'b011);
        chk("t1_idle", busy, 0);

        // 2: dirty miss, victim drained afterwards
        req_valid = 1'b1; req_addr = 4'd9; req_wb = 1'b1;
        req_wb_addr = 4'd1; req_wb_data = 3'b110;
        tick();
        req_valid = 1'b0; req_wb = 1'b0;
        chk("t2_wb_count", wb_count, 1);
        chk("t2_mem_addr", mem_addr, 9);
        tick();
        tick();
        chk("t2_resp_valid", resp_valid, 1);
        chk("t2_resp_data", resp_data, 3'b100);
        tick();
        chk("t2_busy_idle", busy, 1);
        tick();
        chk("t2_drain_wren", mem_wren, 1);
        chk("t2_drain_addr", mem_addr, 1);
        chk("t2_drain_data", mem_wdata, 3'b110);
        tick();
        chk("t2_wb_empty", wb_count, 0);
        chk("t2_wren_off", mem_wren, 0);
        chk("t2_mem1", mem[1], 3'b110);

        // 3: forward from buffer, drain held off by back-to-back requests
        req_valid = 1'b1; req_addr = 4'd2; req_wb = 1'b1;
        req_wb_addr = 4'd6; req_wb_data = 3'b101;
        tick();
        req_valid = 1'b0; req_wb = 1'b0;
        chk("t3_wb_count", wb_count, 1);
        tick();
        tick();
        chk("t3_miss_resp", resp_valid, 1);
        chk("t3_miss_data", resp_data, 3'b010);
        req_valid = 1'b1; req_addr = 4'd6;
        tick();
        chk("t3_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("t3_fwd_valid", resp_valid, 1);
        chk("t3_fwd_data", resp_data, 3'b101);
        chk("t3_fwd_no_rd", mem_addr, 0);
        chk("t3_fwd_wren", mem_wren, 0);
        wait_idle("t3_drain_done");
        chk("t3_mem6", mem[6], 3'b101);

        // 4: full buffer forces a drain before the third request
        req_valid = 1'b1; req_addr = 4'd4; req_wb = 1'b1;
        req_wb_addr = 4'd10; req_wb_data = 3'b001;
        tick();
        tick();
        tick();
        req_addr = 4'd5; req_wb_addr = 4'd11; req_wb_data = 3'b010;
        tick();
        chk("t4_ready_b", req_ready, 1);
        tick();
        chk("t4_count_full", wb_count, 2);
        req_addr = 4'd7; req_wb = 1'b0;
        tick();
        chk("t4_notready_wait", req_ready, 0);
        tick();
        chk("t4_resp_b", resp_data, 3'b011);
        tick();
        chk("t4_notready_full", req_ready, 0);
        chk("t4_count_idle", wb_count, 2);
        tick();
        chk("t4_drain_wren", mem_wren, 1);
        chk("t4_drain_addr", mem_addr, 10);
        chk("t4_drain_data", mem_wdata, 3'b001);
        chk("t4_drain_ready", req_ready, 0);
        tick();
        chk("t4_ready_after", req_ready, 1);
        chk("t4_count_one", wb_count, 1);
        tick();
        req_valid = 1'b0;
        chk("t4_c_addr", mem_addr, 7);
        chk("t4_c_wren", mem_wren, 0);
        tick();
        tick();
        chk("t4_c_resp", resp_data, 3'b111);
        wait_idle("t4_drain_done");
        chk("t4_mem10", mem[10], 3'b001);
        chk("t4_mem11", mem[11], 3'b010);

        // 5: two victims at address 3 coalesce into one entry
        w0 = wren_cycles;
        req_valid = 1'b1; req_addr = 4'd8; req_wb = 1'b1;
        req_wb_addr = 4'd3; req_wb_data = 3'b001;
        tick();
        chk("t5_count_a", wb_count, 1);
        tick();
        tick();
        req_addr = 4'd12; req_wb_data = 3'b111;
        tick();
        tick();
        req_valid = 1'b0; req_wb = 1'b0;
        chk("t5_count_b", wb_count, 1);
        wait_idle("t5_drain_done");
        chk("t5_one_drain", wren_cycles - w0, 1);
        chk("t5_mem3", mem[3], 3'b111);

        // 6: asynchronous reset during RD_WAIT
        req_valid = 1'b1; req_addr = 4'd13; req_wb = 1'b1;
        req_wb_addr = 4'd14; req_wb_data = 3'b110;
        tick();
        req_valid = 1'b0; req_wb = 1'b0;
        chk("t6_count", wb_count, 1);
        tick();
        chk("t6_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_addr", mem_addr, 0);
        chk("t6_rst_count", wb_count, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_resp", resp_valid, 0);
        chk("t6_rst_ready", req_ready, 1);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        req_valid = 1'b1; req_addr = 4'd5;
        tick();
        req_valid = 1'b0;
        chk("t6_post_addr", mem_addr, 5);
        tick();
        tick();
        chk("t6_post_valid", resp_valid, 1);
        chk("t6_post_data", resp_data, 3'b011);
        wait_idle("t6_idle");
        chk("t6_victim_dropped", mem[14], 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
